// File: rtl/avl_bus_arbiter.sv
// Round-robin arbiter sharing one avl slave port among MASTER_NUM masters.
// Read responses are steered back to their issuer through an in-order FIFO of master indices.
module avl_bus_arbiter #(
  parameter int MASTER_NUM      = 4,
  parameter int OUTSTANDING_MAX = 4
) (
  input  logic                        clk,
  input  logic                        rest,
  input  logic [MASTER_NUM-1:0][31:0] m_address,
  input  logic [MASTER_NUM-1:0][3:0]  m_byte_en,
  input  logic [MASTER_NUM-1:0]       m_read,
  input  logic [MASTER_NUM-1:0]       m_write,
  input  logic [MASTER_NUM-1:0][31:0] m_write_data,
  output logic [MASTER_NUM-1:0]       m_request_ready,
  output logic [31:0]                 m_read_data,
  output logic [MASTER_NUM-1:0]       m_resp_ready,
  output logic [31:0]                 s_address,
  output logic [3:0]                  s_byte_en,
  output logic                        s_read,
  output logic                        s_write,
  output logic [31:0]                 s_write_data,
  output logic                        s_begin_burst_transfer,
  output logic [7:0]                  s_burst_count,
  input  logic                        s_request_ready,
  input  logic [31:0]                 s_read_data,
  input  logic                        s_resp_ready,
  output logic                        err_unexpected_resp
);

  localparam int IDX_W = (MASTER_NUM > 1) ? $clog2(MASTER_NUM) : 1;
  localparam int PTR_W = (OUTSTANDING_MAX > 1) ? $clog2(OUTSTANDING_MAX) : 1;
  localparam int CNT_W = $clog2(OUTSTANDING_MAX + 1);

  logic [MASTER_NUM-1:0] req;
  logic [IDX_W-1:0]      rr_ptr;
  logic [IDX_W-1:0]      rr_idx;
  logic                  rr_found;
  logic [IDX_W-1:0]      cand;
  logic                  lock;
  logic [IDX_W-1:0]      lock_idx;
  logic [IDX_W-1:0]      gnt_idx;
  logic                  gnt_valid;
  logic                  sel_read;
  logic                  sel_write;
  logic                  accept;
  logic                  push;
  logic                  pop;
  logic                  full;
  logic                  empty;
  logic [IDX_W-1:0]      head;
  logic [IDX_W-1:0]      fifo_mem [OUTSTANDING_MAX];
  logic [PTR_W-1:0]      wr_ptr;
  logic [PTR_W-1:0]      rd_ptr;
  logic [CNT_W-1:0]      count;

  assign req = m_read | m_write;

  // Walk downwards so the last hit written is the one closest to rr_ptr.
  always_comb begin
    rr_found = 1'b0;
    rr_idx   = '0;
    cand     = '0;
    for (int k = MASTER_NUM - 1; k >= 0; k--) begin
      cand = IDX_W'((int'(rr_ptr) + k) % MASTER_NUM);
      if (req[cand]) begin
        rr_found = 1'b1;
        rr_idx   = cand;
      end
    end
  end

  assign gnt_idx   = lock ? lock_idx : rr_idx;
  assign gnt_valid = lock ? req[lock_idx] : rr_found;

  assign sel_read  = gnt_valid & m_read[gnt_idx];
  assign sel_write = gnt_valid & m_write[gnt_idx] & ~m_read[gnt_idx];

  // Full is taken from the registered count so a same-cycle pop cannot admit a read.
  assign full  = (count == CNT_W'(OUTSTANDING_MAX));
  assign empty = (count == '0);

  assign s_read  = sel_read & ~full & ~rest;
  assign s_write = sel_write & ~rest;
  assign accept  = (s_read | s_write) & s_request_ready;

  assign s_address    = gnt_valid ? m_address[gnt_idx]    : 32'h0;
  assign s_byte_en    = gnt_valid ? m_byte_en[gnt_idx]    : 4'h0;
  assign s_write_data = gnt_valid ? m_write_data[gnt_idx] : 32'h0;

  assign s_begin_burst_transfer = 1'b0;
  assign s_burst_count          = 8'h0;

  always_comb begin
    m_request_ready = '0;
    if (accept) m_request_ready[gnt_idx] = 1'b1;
  end

  assign push = accept & s_read;
  assign pop  = s_resp_ready & ~empty & ~rest;
  assign head = fifo_mem[rd_ptr];

  always_comb begin
    m_resp_ready = '0;
    if (pop) m_resp_ready[head] = 1'b1;
  end

  assign m_read_data = s_read_data;

  always_ff @(posedge clk) begin
    if (rest) begin
      rr_ptr              <= '0;
      lock                <= 1'b0;
      lock_idx            <= '0;
      wr_ptr              <= '0;
      rd_ptr              <= '0;
      count               <= '0;
      err_unexpected_resp <= 1'b0;
    end else begin
      // A blocked read also counts as not accepted, so the grant stays put.
      lock <= gnt_valid & ~accept;
      if (gnt_valid & ~accept) lock_idx <= gnt_idx;
      if (accept) rr_ptr <= (gnt_idx == IDX_W'(MASTER_NUM - 1)) ? '0 : gnt_idx + 1'b1;
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if (s_resp_ready & empty) err_unexpected_resp <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rest && push) fifo_mem[wr_ptr] <= gnt_idx;
  end

endmodule

// File: tb/tb_avl_bus_arbiter.sv
// Directed bench for avl_bus_arbiter followed by a randomized master/slave soak with an order scoreboard.
module tb_avl_bus_arbiter;

  logic              clk = 1'b0;
  logic              rest;
  logic [3:0][31:0]  m_address;
  logic [3:0][3:0]   m_byte_en;
  logic [3:0]        m_read;
  logic [3:0]        m_write;
  logic [3:0][31:0]  m_write_data;
  logic [3:0]        m_request_ready;
  logic [31:0]       m_read_data;
  logic [3:0]        m_resp_ready;
  logic [31:0]       s_address;
  logic [3:0]        s_byte_en;
  logic              s_read;
  logic              s_write;
  logic [31:0]       s_write_data;
  logic              s_begin_burst_transfer;
  logic [7:0]        s_burst_count;
  logic              s_request_ready;
  logic [31:0]       s_read_data;
  logic              s_resp_ready;
  logic              err_unexpected_resp;

  int tests = 0;
  int fails = 0;

  avl_bus_arbiter #(.MASTER_NUM(4), .OUTSTANDING_MAX(4)) dut (
    .clk                    (clk),
    .rest                   (rest),
    .m_address              (m_address),
    .m_byte_en              (m_byte_en),
    .m_read                 (m_read),
    .m_write                (m_write),
    .m_write_data           (m_write_data),
    .m_request_ready        (m_request_ready),
    .m_read_data            (m_read_data),
    .m_resp_ready           (m_resp_ready),
    .s_address              (s_address),
    .s_byte_en              (s_byte_en),
    .s_read                 (s_read),
    .s_write                (s_write),
    .s_write_data           (s_write_data),
    .s_begin_burst_transfer (s_begin_burst_transfer),
    .s_burst_count          (s_burst_count),
    .s_request_ready        (s_request_ready),
    .s_read_data            (s_read_data),
    .s_resp_ready           (s_resp_ready),
    .err_unexpected_resp    (err_unexpected_resp)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  int          pg;
  int          g;
  int          ei;
  logic [31:0] ed;
  logic [3:0]  acc;
  bit          busy [4];
  int          sb_idx [$];
  logic [31:0] sb_dat [$];
  logic [31:0] sq [$];

  initial begin
    rest = 1'b1;
    m_address = '0; m_byte_en = '0; m_read = '0; m_write = '0; m_write_data = '0;
    s_request_ready = 1'b0; s_read_data = '0; s_resp_ready = 1'b0;
    step();

    // requests are gated off while reset is held
    m_write = 4'b0100;
    s_request_ready = 1'b1;
    #1;
    chk("rst_s_write", s_write, 0);
    chk("rst_req_ready", m_request_ready, 4'b0000);
    step();
    rest = 1'b0;
    m_write = 4'b0000;
    #1;
    chk("rst_err", err_unexpected_resp, 0);
    chk("rst_count", dut.count, 0);
    chk("rst_rr_ptr", dut.rr_ptr, 0);
    chk("burst_count", s_burst_count, 0);
    chk("begin_burst", s_begin_burst_transfer, 0);

    // single write from master 2
    m_address[2] = 32'h100; m_write_data[2] = 32'hA5A5A5A5; m_byte_en[2] = 4'hF;
    m_write = 4'b0100;
    #1;
    chk("single_s_write", s_write, 1);
    chk("single_s_read", s_read, 0);
    chk("single_addr", s_address, 32'h100);
    chk("single_data", s_write_data, 32'hA5A5A5A5);
    chk("single_be", s_byte_en, 4'hF);
    chk("single_req_ready", m_request_ready, 4'b0100);
    step();
    m_write = 4'b0000;
    chk("single_rr_ptr", dut.rr_ptr, 3);

    // all four reading, immediate responses; pointer starts at 3
    for (int i = 0; i < 4; i++) m_address[i] = 32'h1000 + i * 16;
    m_read = 4'b1111;
    pg = 0;
    for (int c = 0; c < 6; c++) begin
      g = (3 + c) % 4;
      if (c > 0) begin
        s_resp_ready = 1'b1;
        s_read_data  = ~(32'h1000 + pg * 16);
      end
      #1;
      chk("rr_grant", m_request_ready, 4'b0001 << g);
      chk("rr_addr", s_address, 32'h1000 + g * 16);
      chk("rr_s_read", s_read, 1);
      if (c > 0) begin
        chk("rr_resp", m_resp_ready, 4'b0001 << pg);
        chk("rr_rdata", m_read_data, ~(32'h1000 + pg * 16));
      end
      step();
      chk("rr_count", dut.count, 1);
      pg = g;
    end
    m_read = 4'b0000;
    s_resp_ready = 1'b1;
    s_read_data = ~32'h1000;
    #1;
    chk("rr_last_resp", m_resp_ready, 4'b0001);
    step();
    s_resp_ready = 1'b0;
    chk("rr_drained", dut.count, 0);
    chk("rr_ptr_after", dut.rr_ptr, 1);

    // move the pointer to 0 so a lock is observable
    m_address[3] = 32'h40;
    m_write = 4'b1000;
    #1;
    chk("w3_req_ready", m_request_ready, 4'b1000);
    step();
    m_write = 4'b0000;
    chk("w3_rr_ptr", dut.rr_ptr, 0);

    // master 1 stalled three cycles; master 0 arrives on the second
    s_request_ready = 1'b0;
    m_address[1] = 32'h2000;
    m_read = 4'b0010;
    #1;
    chk("lock_c1_addr", s_address, 32'h2000);
    chk("lock_c1_s_read", s_read, 1);
    chk("lock_c1_ready", m_request_ready, 4'b0000);
    step();
    m_address[0] = 32'h3000;
    m_read = 4'b0011;
    #1;
    chk("lock_c2_addr", s_address, 32'h2000);
    chk("lock_c2_ready", m_request_ready, 4'b0000);
    step();
    chk("lock_c3_addr", s_address, 32'h2000);
    step();
    s_request_ready = 1'b1;
    #1;
    chk("lock_accept", m_request_ready, 4'b0010);
    chk("lock_accept_addr", s_address, 32'h2000);
    step();
    m_read = 4'b0001;
    #1;
    chk("lock_next", m_request_ready, 4'b0001);
    chk("lock_next_addr", s_address, 32'h3000);
    step();
    m_read = 4'b0000;
    chk("lock_count", dut.count, 2);

    // responses return in issue order: master 1 then master 0
    s_resp_ready = 1'b1;
    s_read_data = 32'h11111111;
    #1;
    chk("order_resp1", m_resp_ready, 4'b0010);
    chk("order_data1", m_read_data, 32'h11111111);
    step();
    s_read_data = 32'h22222222;
    #1;
    chk("order_resp0", m_resp_ready, 4'b0001);
    step();
    s_resp_ready = 1'b0;
    chk("order_count", dut.count, 0);

    // fill the FIFO with four reads from master 2
    m_address[2] = 32'h5000;
    m_read = 4'b0100;
    for (int c = 0; c < 4; c++) begin
      #1;
      chk("fill_ready", m_request_ready, 4'b0100);
      step();
    end
    m_read = 4'b0000;
    chk("fill_count", dut.count, 4);
    m_address[3] = 32'h4000;
    m_write = 4'b1000;
    #1;
    chk("full_write", s_write, 1);
    chk("full_write_ready", m_request_ready, 4'b1000);
    step();
    m_write = 4'b0000;
    chk("full_write_count", dut.count, 4);
    m_read = 4'b0100;
    #1;
    chk("full_block_s_read", s_read, 0);
    chk("full_block_ready", m_request_ready, 4'b0000);
    step();
    chk("full_block2", m_request_ready, 4'b0000);
    s_resp_ready = 1'b1;
    s_read_data = 32'h33;
    #1;
    chk("full_samecycle_pop", s_read, 0);
    chk("full_pop_resp", m_resp_ready, 4'b0100);
    step();
    s_resp_ready = 1'b0;
    #1;
    chk("full_unblock_s_read", s_read, 1);
    chk("full_unblock_ready", m_request_ready, 4'b0100);
    step();
    m_read = 4'b0000;
    chk("full_refill_count", dut.count, 4);

    for (int c = 0; c < 4; c++) begin
      s_resp_ready = 1'b1;
      #1;
      chk("drain_resp", m_resp_ready, 4'b0100);
      step();
    end
    s_resp_ready = 1'b0;
    chk("drain_count", dut.count, 0);

    // response with nothing outstanding
    s_resp_ready = 1'b1;
    #1;
    chk("unexp_resp", m_resp_ready, 4'b0000);
    chk("unexp_err_pre", err_unexpected_resp, 0);
    step();
    s_resp_ready = 1'b0;
    chk("unexp_err", err_unexpected_resp, 1);
    chk("unexp_count", dut.count, 0);
    step();
    chk("unexp_sticky", err_unexpected_resp, 1);

    // pointer sits at 3, so master 0 beats master 1
    m_address[0] = 32'h60; m_address[1] = 32'h70;
    m_read = 4'b0011;
    #1;
    chk("two_first", m_request_ready, 4'b0001);
    step();
    m_read = 4'b0010;
    #1;
    chk("two_second", m_request_ready, 4'b0010);
    step();
    m_read = 4'b0000;
    chk("two_count", dut.count, 2);

    rest = 1'b1;
    m_read = 4'b0011;
    s_resp_ready = 1'b1;
    #1;
    chk("rst2_req_ready", m_request_ready, 4'b0000);
    chk("rst2_s_read", s_read, 0);
    chk("rst2_resp", m_resp_ready, 4'b0000);
    step();
    rest = 1'b0;
    m_read = 4'b0000;
    s_resp_ready = 1'b0;
    chk("rst2_count", dut.count, 0);
    chk("rst2_err", err_unexpected_resp, 0);
    chk("rst2_rr_ptr", dut.rr_ptr, 0);

    // random soak: masters hold until accepted, slave answers after a random delay
    for (int i = 0; i < 4; i++) busy[i] = 1'b0;
    for (int cyc = 0; cyc < 10000; cyc++) begin
      for (int i = 0; i < 4; i++) begin
        if (!busy[i] && $urandom_range(0, 3) == 0) begin
          busy[i] = 1'b1;
          m_address[i] = $urandom;
          m_write_data[i] = $urandom;
          m_byte_en[i] = 4'($urandom);
          if ($urandom_range(0, 2) != 0) m_read[i] = 1'b1;
          else m_write[i] = 1'b1;
        end
      end
      s_request_ready = ($urandom_range(0, 3) != 0);
      if (sq.size() > 0 && $urandom_range(0, 2) == 0) begin
        s_resp_ready = 1'b1;
        s_read_data = sq[0];
      end else begin
        s_resp_ready = 1'b0;
        s_read_data = $urandom;
      end
      #1;
      if (s_resp_ready) begin
        void'(sq.pop_front());
        if (sb_idx.size() == 0) begin
          tests++;
          fails++;
          $error("FAIL soak_order: observed response with no accepted read, expected none");
        end else begin
          ei = sb_idx.pop_front();
          ed = sb_dat.pop_front();
          chk("soak_resp_idx", m_resp_ready, 4'b0001 << ei);
          chk("soak_resp_data", m_read_data, ed);
        end
      end
      acc = m_request_ready;
      for (int i = 0; i < 4; i++)
        if (acc[i] && m_read[i]) begin
          sb_idx.push_back(i);
          sb_dat.push_back(~m_address[i]);
        end
      if (s_read && s_request_ready) sq.push_back(~s_address);
      step();
      for (int i = 0; i < 4; i++)
        if (acc[i]) begin
          m_read[i] = 1'b0;
          m_write[i] = 1'b0;
          busy[i] = 1'b0;
        end
    end
    chk("soak_err", err_unexpected_resp, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
